// File: rtl/wave_reader.sv
// Read-side sequencer for the sample ROM: a fractional phase accumulator drives
// the ROM address and each fetched sample is offered on a valid/ready handshake.
module wave_reader #(
    parameter int SIZE     = 32,
    parameter int ADDR_W   = 12,
    parameter int SAMPLE_W = 12,
    parameter int FRAC_W   = 8,
    parameter int PHASE_W  = ADDR_W + FRAC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PHASE_W-1:0]  step,
    output logic [ADDR_W-1:0]   address,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                wrap
);

    localparam logic [PHASE_W:0]   LIM    = (PHASE_W+1)'(SIZE << FRAC_W);
    localparam logic [PHASE_W-1:0] LIM_M1 = PHASE_W'(LIM - 1'b1);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_t;

    state_t                r_state;
    logic [PHASE_W-1:0]    r_phase;
    logic [SAMPLE_W-1:0]   r_sample;
    logic                  r_valid;
    logic                  r_wrap;

    logic [PHASE_W-1:0]    w_step_c;
    logic [PHASE_W:0]      w_nxt;
    logic                  w_wrap;
    logic [PHASE_W-1:0]    w_phase_nxt;

    // Clamp keeps a single subtraction sufficient to bring the phase back in range.
    assign w_step_c    = ({1'b0, step} >= LIM) ? LIM_M1 : step;
    assign w_nxt       = {1'b0, r_phase} + {1'b0, w_step_c};
    assign w_wrap      = (w_nxt >= LIM);
    assign w_phase_nxt = w_wrap ? PHASE_W'(w_nxt - LIM) : w_nxt[PHASE_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) r_state <= FETCH;
                end
                FETCH: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_sample <= sample_in;
                    r_valid  <= 1'b1;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    // en is only honoured once the pending sample is accepted.
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_phase <= w_phase_nxt;
                        r_wrap  <= w_wrap;
                        r_state <= en ? FETCH : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign address    = r_phase[PHASE_W-1:FRAC_W];
    assign out_sample = r_sample;
    assign out_valid  = r_valid;
    assign wrap       = r_wrap;

endmodule
